// File: rtl/riscv_pkg.sv
// Shared encodings for the pipeline memory path: access sizes, controller FSM
// states, request owner and a size-to-byte-count helper.
package riscv_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } mem_ctrl_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } mem_owner_t;

  // Encoding 11 is treated as a word access.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial controller sharing one 8-bit RAM port between instruction fetch
// and data access; MEM wins arbitration, each request is split into byte transfers.
module mem_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_done_o,
  output logic              if_stall_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              mem_stall_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output mem_ctrl_state_t   dbg_state_o
);

  mem_ctrl_state_t   r_state;
  mem_owner_t        r_owner;
  logic [2:0]        r_k;
  logic [2:0]        r_n;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;

  logic [ADDR_W-1:0] w_addr_k;
  logic [1:0]        w_rd_lane;
  logic              w_xfer;
  logic              w_done_if;
  logic              w_done_mem;

  assign w_addr_k   = r_addr + ADDR_W'(r_k);
  // RAM data lags the address by one cycle, so counter k fills lane k-1.
  assign w_rd_lane  = 2'(r_k - 3'd1);
  assign w_xfer     = (r_state == RD) || (r_state == WR);
  assign w_done_if  = (r_state == DONE) && (r_owner == OWN_IF);
  assign w_done_mem = (r_state == DONE) && (r_owner == OWN_MEM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= OWN_IF;
      r_k     <= 3'd0;
      r_n     <= 3'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_req_i) begin
            r_owner <= OWN_MEM;
            r_addr  <= mem_addr_i;
            r_n     <= size_to_bytes(mem_size_i);
            r_wdata <= mem_wdata_i;
            r_rdata <= '0;
            r_k     <= 3'd0;
            r_state <= mem_we_i ? WR : RD;
          end else if (if_req_i) begin
            r_owner <= OWN_IF;
            r_addr  <= if_addr_i;
            r_n     <= 3'd4;
            r_wdata <= '0;
            r_rdata <= '0;
            r_k     <= 3'd0;
            r_state <= RD;
          end
        end
        RD: begin
          if (r_k != 3'd0) r_rdata[{w_rd_lane, 3'b000} +: 8] <= ram_din_i;
          if (r_k == r_n) r_state <= DONE;
          else            r_k     <= r_k + 3'd1;
        end
        WR: begin
          if (r_k == r_n - 3'd1) r_state <= DONE;
          else                   r_k     <= r_k + 3'd1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // A write strobe must never escape while reset is asserted.
  assign ram_wr_o    = rst && (r_state == WR);
  assign ram_addr_o  = w_xfer ? w_addr_k : '0;
  assign ram_dout_o  = (r_state == WR) ? r_wdata[{r_k[1:0], 3'b000} +: 8] : 8'h00;

  assign if_done_o   = w_done_if;
  assign mem_done_o  = w_done_mem;
  assign if_rdata_o  = w_done_if  ? r_rdata : 32'h0;
  assign mem_rdata_o = w_done_mem ? r_rdata : 32'h0;

  assign if_stall_o  = if_req_i  && !w_done_if;
  assign mem_stall_o = mem_req_i && !w_done_mem;

  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a 1-cycle-latency byte RAM, a byte-level
// reference memory and per-scenario tasks checking timing, data and RAM traffic.
module tb_mem_ctrl;
  import riscv_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req = 1'b0;
  logic [31:0]     if_addr = '0;
  logic [31:0]     if_rdata_o;
  logic            if_done_o;
  logic            if_stall_o;
  logic            mem_req = 1'b0;
  logic            mem_we = 1'b0;
  logic [1:0]      mem_size = 2'b00;
  logic [31:0]     mem_addr = '0;
  logic [31:0]     mem_wdata = '0;
  logic [31:0]     mem_rdata_o;
  logic            mem_done_o;
  logic            mem_stall_o;
  logic [7:0]      ram_din;
  logic [7:0]      ram_dout_o;
  logic [31:0]     ram_addr_o;
  logic            ram_wr_o;
  mem_ctrl_state_t dbg_state_o;

  int tests_run = 0;
  int tests_failed = 0;
  int unsigned cyc = 0;
  int unsigned c0 = 0;

  int unsigned wr_cyc[$];
  logic [31:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  logic [31:0] exp_q[$];

  logic [7:0] ram [0:4095];
  logic       ram_ready = 1'b0;
  logic [7:0] model_mem [logic [31:0]];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata_o),
    .if_done_o(if_done_o), .if_stall_o(if_stall_o),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_size_i(mem_size),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata_o),
    .mem_done_o(mem_done_o), .mem_stall_o(mem_stall_o),
    .ram_din_i(ram_din), .ram_dout_o(ram_dout_o), .ram_addr_o(ram_addr_o),
    .ram_wr_o(ram_wr_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Test addresses are chosen so this folded index never aliases two live bytes.
  function automatic logic [11:0] ram_idx(input logic [31:0] a);
    return {a[15:12], a[7:0]};
  endfunction

  function automatic logic [7:0] rom_byte(input logic [11:0] i);
    case (i)
      12'h100: return 8'h10;
      12'h101: return 8'h11;
      12'h102: return 8'h12;
      12'h103: return 8'h13;
      12'h300: return 8'h34;
      12'h301: return 8'h12;
      12'h302: return 8'h56;
      12'h303: return 8'h78;
      default: return i[7:0] ^ {i[11:8], i[11:8]} ^ 8'hA5;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 4096; i++) ram[i] <= rom_byte(12'(i));
      ram_ready <= 1'b1;
    end else begin
      ram_din <= ram[ram_idx(ram_addr_o)];
      if (ram_wr_o) ram[ram_idx(ram_addr_o)] <= ram_dout_o;
    end
  end

  always @(negedge clk) begin
    if (ram_wr_o === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(ram_addr_o);
      wr_data.push_back(ram_dout_o);
    end
  end

  function automatic logic [7:0] model_rd(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return rom_byte(ram_idx(a));
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = r | (32'(model_rd(a + 32'(i))) << (8 * i));
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) model_mem[a + 32'(i)] = d[8*i +: 8];
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  // Raises one request at an IDLE cycle (cycle 0), reports done cycle, data and
  // the first cycle whose stall value was wrong (-1 when none).
  task automatic drive_txn(input bit is_mem, input bit we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int done_cyc, output logic [31:0] rdata,
                           output int stall_bad);
    bit stall, done;
    done_cyc = -1;
    stall_bad = -1;
    rdata = '0;
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    c0 = cyc;
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      stall = is_mem ? mem_stall_o : if_stall_o;
      done  = is_mem ? mem_done_o : if_done_o;
      if (done) begin
        done_cyc = c;
        rdata = is_mem ? mem_rdata_o : if_rdata_o;
        if (stall && stall_bad < 0) stall_bad = c;
        break;
      end
      if (!stall && stall_bad < 0) stall_bad = c;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    mem_req = 1'b0;
    if_req = 1'b0;
  endtask

  task automatic test_reset();
    int mem_d, if_d;
    logic [31:0] mem_rd, if_rd;
    bit first_mem;
    mem_d = -1; if_d = -1; mem_rd = '0; if_rd = '0; first_mem = 1'b0;
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h1000;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = SZ_BYTE; mem_addr = 32'h3000;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); @(negedge clk);
      tests_run++;
      if ({if_done_o, mem_done_o, ram_wr_o} !== 3'b000 || if_rdata_o !== 32'h0 || mem_rdata_o !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_outputs: got done=%b%b wr=%b rdata=%h/%h, required all zero",
                 if_done_o, mem_done_o, ram_wr_o, if_rdata_o, mem_rdata_o);
      end
    end
    rst = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin @(posedge clk); @(negedge clk); end
      if (mem_done_o === 1'b1 && mem_d < 0) begin
        mem_d = c; mem_rd = mem_rdata_o; first_mem = (if_d < 0);
        mem_req = 1'b0;
      end
      if (if_done_o === 1'b1 && if_d < 0) begin
        if_d = c; if_rd = if_rdata_o; if_req = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    mem_req = 1'b0; if_req = 1'b0;
    tests_run++;
    if (!first_mem || mem_d !== 3) begin
      tests_failed++;
      $display("FAIL reset_mem_first: got mem_done cycle %0d (first=%b), required cycle 3 first", mem_d, first_mem);
    end
    tests_run++;
    if (mem_rd !== model_word(32'h3000, 1)) begin
      tests_failed++;
      $display("FAIL reset_mem_rdata: got %h, required %h", mem_rd, model_word(32'h3000, 1));
    end
    tests_run++;
    if (if_d !== 10 || if_rd !== 32'h13121110) begin
      tests_failed++;
      $display("FAIL reset_if_after: got cycle %0d data %h, required cycle 10 data 13121110", if_d, if_rd);
    end
  endtask

  task automatic test_if_fetch();
    int dc, sb;
    logic [31:0] rd;
    drive_txn(1'b0, 1'b0, SZ_WORD, 32'h1000, 32'h0, dc, rd, sb);
    tests_run++;
    if (dc !== 6) begin
      tests_failed++; $display("FAIL if_done_cycle: got %0d, required 6", dc);
    end
    tests_run++;
    if (rd !== 32'h13121110) begin
      tests_failed++; $display("FAIL if_rdata: got %h, required 13121110", rd);
    end
    tests_run++;
    if (sb !== -1) begin
      tests_failed++; $display("FAIL if_stall: wrong stall value in cycle %0d, required high 0..5 low 6", sb);
    end
  endtask

  task automatic test_mem_byte_write();
    int dc, sb;
    logic [31:0] rd;
    drive_txn(1'b1, 1'b1, SZ_BYTE, 32'h2003, 32'h123456AB, dc, rd, sb);
    model_write(32'h2003, 1, 32'h123456AB);
    tests_run++;
    if (wr_addr.size() !== 1) begin
      tests_failed++; $display("FAIL byte_wr_count: got %0d pulses, required 1", wr_addr.size());
    end else begin
      tests_run++;
      if (wr_cyc[0] - c0 !== 1 || wr_addr[0] !== 32'h2003 || wr_data[0] !== 8'hAB) begin
        tests_failed++;
        $display("FAIL byte_wr_pulse: got cycle %0d addr %h data %h, required cycle 1 addr 00002003 data ab",
                 wr_cyc[0] - c0, wr_addr[0], wr_data[0]);
      end
    end
    tests_run++;
    if (dc !== 2 || sb !== -1) begin
      tests_failed++; $display("FAIL byte_wr_done: got done %0d stall_bad %0d, required done 2 stall_bad -1", dc, sb);
    end
  endtask

  task automatic test_simultaneous();
    int mem_d, if_d;
    logic [31:0] mem_rd, if_rd;
    mem_d = -1; if_d = -1; mem_rd = '0; if_rd = '0;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = SZ_HALF; mem_addr = 32'h3000;
    if_req = 1'b1; if_addr = 32'h3000;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_done_o === 1'b1 && mem_d < 0) begin
        mem_d = c; mem_rd = mem_rdata_o; mem_req = 1'b0;
      end
      if (if_done_o === 1'b1) begin
        if_d = c; if_rd = if_rdata_o; if_req = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    mem_req = 1'b0; if_req = 1'b0;
    tests_run++;
    if (mem_d !== 4 || mem_rd !== 32'h00001234) begin
      tests_failed++; $display("FAIL sim_mem: got cycle %0d data %h, required cycle 4 data 00001234", mem_d, mem_rd);
    end
    tests_run++;
    if (if_d !== 11 || if_rd !== model_word(32'h3000, 4)) begin
      tests_failed++; $display("FAIL sim_if: got cycle %0d data %h, required cycle 11 data %h",
                               if_d, if_rd, model_word(32'h3000, 4));
    end
  endtask

  task automatic test_reset_mid_write();
    bit seen_done;
    seen_done = 1'b0;
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    mem_req = 1'b1; mem_we = 1'b1; mem_size = SZ_WORD; mem_addr = 32'h5000; mem_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) begin rst = 1'b0; mem_req = 1'b0; end
      if (c == 4) rst = 1'b1;
      @(negedge clk);
      if (mem_done_o === 1'b1) seen_done = 1'b1;
      if (c == 3) begin
        tests_run++;
        if (ram_wr_o !== 1'b0) begin
          tests_failed++; $display("FAIL rstw_gate: got ram_wr_o %b in reset cycle, required 0", ram_wr_o);
        end
      end
      if (c == 4) begin
        tests_run++;
        if (dbg_state_o !== IDLE) begin
          tests_failed++; $display("FAIL rstw_idle: got state %0d, required IDLE", dbg_state_o);
        end
      end
      @(posedge clk); #1;
    end
    model_write(32'h5000, 2, 32'hDEADBEEF);
    tests_run++;
    if (seen_done) begin
      tests_failed++; $display("FAIL rstw_done: got a mem_done pulse, required none");
    end
    tests_run++;
    if (wr_addr.size() !== 2 || ram[ram_idx(32'h5000)] !== 8'hEF || ram[ram_idx(32'h5001)] !== 8'hBE
        || ram[ram_idx(32'h5002)] !== model_rd(32'h5002) || ram[ram_idx(32'h5003)] !== model_rd(32'h5003)) begin
      tests_failed++;
      $display("FAIL rstw_bytes: got %0d writes, ram %h %h %h %h, required 2 writes ef be %h %h",
               wr_addr.size(), ram[ram_idx(32'h5000)], ram[ram_idx(32'h5001)], ram[ram_idx(32'h5002)],
               ram[ram_idx(32'h5003)], model_rd(32'h5002), model_rd(32'h5003));
    end
  endtask

  task automatic check_write_log(input string name, input logic [31:0] a, input int n, input logic [31:0] d);
    tests_run++;
    if (wr_addr.size() !== n) begin
      tests_failed++; $display("FAIL %s_wr_count: got %0d, required %0d", name, wr_addr.size(), n);
      return;
    end
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (wr_cyc[i] - c0 !== 32'(i + 1) || wr_addr[i] !== a + 32'(i) || wr_data[i] !== d[8*i +: 8]) begin
        tests_failed++;
        $display("FAIL %s_wr_byte%0d: got cycle %0d addr %h data %h, required cycle %0d addr %h data %h",
                 name, i, wr_cyc[i] - c0, wr_addr[i], wr_data[i], i + 1, a + 32'(i), d[8*i +: 8]);
      end
    end
  endtask

  task automatic test_write_readback();
    int dc, sb;
    logic [31:0] rd;
    drive_txn(1'b1, 1'b1, SZ_WORD, 32'h4001, 32'hDEADBEEF, dc, rd, sb);
    model_write(32'h4001, 4, 32'hDEADBEEF);
    check_write_log("wb", 32'h4001, 4, 32'hDEADBEEF);
    tests_run++;
    if (dc !== 5 || sb !== -1) begin
      tests_failed++; $display("FAIL wb_write_done: got done %0d stall_bad %0d, required 5 and -1", dc, sb);
    end
    drive_txn(1'b1, 1'b0, SZ_WORD, 32'h4001, 32'h0, dc, rd, sb);
    tests_run++;
    if (dc !== 6 || rd !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL wb_read: got cycle %0d data %h, required cycle 6 data deadbeef", dc, rd);
    end
  endtask

  task automatic test_wrap();
    int dc, sb;
    logic [31:0] rd, d;
    d = $urandom;
    drive_txn(1'b1, 1'b1, 2'b11, 32'hFFFFFFFE, d, dc, rd, sb);
    model_write(32'hFFFFFFFE, 4, d);
    check_write_log("wrap", 32'hFFFFFFFE, 4, d);
    drive_txn(1'b1, 1'b0, SZ_HALF, 32'hFFFFFFFF, 32'h0, dc, rd, sb);
    tests_run++;
    if (dc !== 4 || rd !== model_word(32'hFFFFFFFF, 2)) begin
      tests_failed++; $display("FAIL wrap_read: got cycle %0d data %h, required cycle 4 data %h",
                               dc, rd, model_word(32'hFFFFFFFF, 2));
    end
  endtask

  task automatic test_back_to_back_random();
    int dc, sb, n, lat;
    logic [31:0] rd, a, d, e;
    logic [1:0] sz;
    bit is_mem, we;
    for (int t = 0; t < 24; t++) begin
      is_mem = ($urandom_range(0, 2) != 0);
      we = is_mem && ($urandom_range(0, 1) == 1);
      sz = is_mem ? 2'($urandom_range(0, 3)) : SZ_WORD;
      n = nbytes(sz);
      a = {16'h0, 4'($urandom_range(6, 9)), 4'h0, 8'($urandom_range(0, 240))};
      d = $urandom;
      lat = we ? n + 1 : n + 2;
      if (!we) exp_q.push_back(model_word(a, n));
      drive_txn(is_mem, we, sz, a, d, dc, rd, sb);
      tests_run++;
      if (dc !== lat || sb !== -1) begin
        tests_failed++;
        $display("FAIL rnd%0d_timing: got done %0d stall_bad %0d, required done %0d stall_bad -1", t, dc, sb, lat);
      end
      if (we) begin
        model_write(a, n, d);
        check_write_log("rnd", a, n, d);
      end else begin
        e = exp_q.pop_front();
        tests_run++;
        if (rd !== e) begin
          tests_failed++; $display("FAIL rnd%0d_rdata: got %h, required %h (addr %h n %0d)", t, rd, e, a, n);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_if_fetch();
    test_mem_byte_write();
    test_simultaneous();
    test_reset_mid_write();
    test_write_readback();
    test_wrap();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
